// File: rtl/neuron_driver.sv
// neuron_driver: initiator for one neuron.
//   Collects NUM_INPUTS serial fixed-point words into a parallel vector.
//   Raises inputs_ready, then waits for output_ready (bounded by TIMEOUT_CYCLES).
//   Presents the captured neuron output on a valid/ready result port.
// Ports:
//   clock, reset                   rising-edge clock, async active-high reset
//   in_valid/in_ready/in_data      upstream word stream (signed Q INTEGER_WIDTH.FRACTION_WIDTH)
//   inputs, inputs_ready           parallel vector + start strobe to neuron (inputs[0] = first word)
//   output_ready, out              neuron completion + result
//   result_valid/result_ready/result  captured result to downstream
//   timeout                        one-cycle pulse when the neuron fails to answer
// All outputs are registered, so no combinational path runs from any input port to any output port.
module neuron_driver #(
  parameter int NUM_INPUTS     = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int INTEGER_WIDTH  = 8,
  parameter int FRACTION_WIDTH = 8,
  localparam int W = INTEGER_WIDTH + FRACTION_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W-1:0]                  in_data,
  output logic [NUM_INPUTS-1:0][W-1:0]  inputs,
  output logic                          inputs_ready,
  input  logic                          output_ready,
  input  logic [W-1:0]                  out,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [W-1:0]                  result,
  output logic                          timeout
);

  localparam int CW = $clog2(NUM_INPUTS) + 1;
  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NUM_INPUTS - 1);
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {LOAD, COMPUTE, DONE} state_t;

  state_t         state, state_nx;
  logic [CW-1:0]  count, count_nx;
  logic [TW-1:0]  tcnt, tcnt_nx;
  logic           in_ready_nx, inputs_ready_nx, result_valid_nx, timeout_nx;
  logic           accept, last_word, expire, capture;

  assign accept    = in_valid && in_ready;
  assign last_word = (count == CNT_LAST);
  // The cycle that would take the wait counter to TIMEOUT_CYCLES is the expiring one.
  assign expire    = (TIMEOUT_CYCLES > 0) && (tcnt == TMO_LAST);
  assign capture   = (state == COMPUTE) && output_ready;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nx;
  end

  // Next-state logic; output_ready beats a simultaneous timeout.
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (accept && last_word) state_nx = COMPUTE;
      COMPUTE: if (output_ready)        state_nx = DONE;
               else if (expire)         state_nx = LOAD;
      DONE:    if (result_ready)        state_nx = LOAD;
      default:                          state_nx = LOAD;
    endcase
  end

  // Output logic: next values for the registered outputs and counters.
  always_comb begin
    in_ready_nx     = (state_nx == LOAD);
    inputs_ready_nx = (state_nx == COMPUTE);
    result_valid_nx = (state_nx == DONE);
    timeout_nx      = (state == COMPUTE) && !output_ready && expire;
    count_nx        = count;
    if (accept) count_nx = last_word ? '0 : count + 1'b1;
    // Held at zero outside COMPUTE so every entry starts a fresh wait.
    tcnt_nx = (state == COMPUTE && !output_ready && !expire) ? tcnt + 1'b1 : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count        <= '0;
      tcnt         <= '0;
      in_ready     <= 1'b0;
      inputs_ready <= 1'b0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      result       <= '0;
    end else begin
      count        <= count_nx;
      tcnt         <= tcnt_nx;
      in_ready     <= in_ready_nx;
      inputs_ready <= inputs_ready_nx;
      result_valid <= result_valid_nx;
      timeout      <= timeout_nx;
      if (capture) result <= out;
    end
  end

  // Vector lanes: each lane loads only when the word index matches, so the
  // vector stays frozen outside LOAD.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    always_ff @(posedge clock or posedge reset) begin
      if (reset)                           inputs[i] <= '0;
      else if (accept && count == CW'(i))  inputs[i] <= in_data;
    end
  end

endmodule
